mem_access_sequencer: RTL and testbench

Multi-cycle memory access controller between the X-Makina control unit and the external memory controller. Accepts one load/store request at a time and classifies it by alignment and PSW address. It then runs the transaction as one of three cases: a misaligned fault, a PSW register access, or a handshaken bus cycle with byte-lane steering. It returns data and fault status to the control unit with a single-cycle acknowledge.

---
 rtl/mem_access_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// X-Makina load/store sequencer: misaligned fault, PSW register access or handshaken bus cycle.
// Define MEM_TIMEOUT_EN to abort bus cycles that wait TIMEOUT_CYC cycles without mem_rdy_i.
module mem_access_sequencer #(
    parameter int              WORD        = 16,
    parameter logic [WORD-1:0] PSW_ADDR    = 16'hFFFC,
    parameter int              TIMEOUT_CYC = 64
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic            byteEn_i,
    input  logic [WORD-1:0] addr_i,
    input  logic [WORD-1:0] wdata_i,
    output logic            ack_o,
    output logic [WORD-1:0] rdata_o,
    output logic            fault_o,
    output logic [1:0]      faultCode_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [WORD-1:0] mem_addr_o,
    output logic [1:0]      mem_sel_o,
    output logic [WORD-1:0] mem_wdata_o,
    input  logic [WORD-1:0] mem_rdata_i,
    input  logic            mem_rdy_i,
    input  logic [WORD-1:0] psw_i,
    output logic            psw_we_o,
    output logic [WORD-1:0] psw_wdata_o
);

    typedef enum logic [1:0] {IDLE, BUS, PSW, DONE} state_t;

    state_t          state;
    state_t          state_next;

    logic            acc_we;
    logic            acc_byte;
    logic [WORD-1:0] acc_addr;
    logic [WORD-1:0] acc_wdata;
    logic [WORD-1:0] rdata;
    logic [1:0]      code;

    logic            misaligned_in;
    logic            bus_timeout;
    logic [WORD-1:0] bus_lane;
    logic [WORD-1:0] psw_rd;

    assign misaligned_in = !byteEn_i && addr_i[0];

    // Byte loads return the addressed lane zero-extended into the low byte.
    assign bus_lane = !acc_byte   ? mem_rdata_i :
                      acc_addr[0] ? {{(WORD-8){1'b0}}, mem_rdata_i[15:8]} :
                                    {{(WORD-8){1'b0}}, mem_rdata_i[7:0]};
    assign psw_rd   = acc_byte ? {{(WORD-8){1'b0}}, psw_i[7:0]} : psw_i;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt <= '0;
        end else if (state != BUS) begin
            wait_cnt <= '0;
        end else if (!mem_rdy_i) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Fires in the last permitted wait cycle; a simultaneous mem_rdy_i still wins.
    assign bus_timeout = (state == BUS) && !mem_rdy_i && (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
    // No counter in this build; the compare keeps TIMEOUT_CYC referenced and folds to 0.
    assign bus_timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_we    <= 1'b0;
            acc_byte  <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            rdata     <= '0;
            code      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        acc_we    <= we_i;
                        acc_byte  <= byteEn_i;
                        acc_addr  <= addr_i;
                        acc_wdata <= wdata_i;
                        rdata     <= '0;
                        code      <= misaligned_in ? 2'd1 : 2'd0;
                    end
                end
                PSW: begin
                    if (!acc_we) begin
                        rdata <= psw_rd;
                    end
                end
                BUS: begin
                    if (mem_rdy_i) begin
                        if (!acc_we) begin
                            rdata <= bus_lane;
                        end
                    end else if (bus_timeout) begin
                        code <= 2'd2;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        ack_o       = 1'b0;
        rdata_o     = '0;
        fault_o     = 1'b0;
        faultCode_o = 2'd0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_sel_o   = 2'd0;
        mem_wdata_o = '0;
        psw_we_o    = 1'b0;
        psw_wdata_o = '0;

        case (state)
            IDLE: begin
                // Misalignment is checked before the PSW address match.
                if (req_i) begin
                    if (misaligned_in) begin
                        state_next = DONE;
                    end else if (addr_i == PSW_ADDR) begin
                        state_next = PSW;
                    end else begin
                        state_next = BUS;
                    end
                end
            end
            BUS: begin
                mem_req_o  = 1'b1;
                mem_we_o   = acc_we;
                mem_addr_o = acc_addr;
                mem_sel_o  = acc_byte ? (acc_addr[0] ? 2'd2 : 2'd1) : 2'd3;
                if (acc_we) begin
                    mem_wdata_o = acc_byte ? {2{acc_wdata[7:0]}} : acc_wdata;
                end
                if (mem_rdy_i || bus_timeout) begin
                    state_next = DONE;
                end
            end
            PSW: begin
                psw_we_o = acc_we;
                if (acc_we) begin
                    psw_wdata_o = acc_byte ? {psw_i[15:8], acc_wdata[7:0]} : acc_wdata;
                end
                state_next = DONE;
            end
            DONE: begin
                ack_o       = 1'b1;
                rdata_o     = rdata;
                fault_o     = (code != 2'd0);
                faultCode_o = code;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized and directed bench for mem_access_sequencer against a transaction-level reference model.
// Honours MEM_TIMEOUT_EN when predicting bus aborts (DUT built with TIMEOUT_CYC=4).
module tb_mem_access_sequencer;

    localparam logic [15:0] PSW_ADDR = 16'hFFFC;
    localparam int          TO       = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit          TO_EN    = 1'b1;
`else
    localparam bit          TO_EN    = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic        byteEn_i = 1'b0;
    logic [15:0] addr_i = '0;
    logic [15:0] wdata_i = '0;
    logic        ack_o;
    logic [15:0] rdata_o;
    logic        fault_o;
    logic [1:0]  faultCode_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [1:0]  mem_sel_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i = '0;
    logic        mem_rdy_i = 1'b0;
    logic [15:0] psw_i = '0;
    logic        psw_we_o;
    logic [15:0] psw_wdata_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        int          lat;
        int          bus_cyc;
        logic [15:0] rdata;
        logic [1:0]  code;
        logic [1:0]  sel;
        logic [15:0] bus_wdata;
        logic        psw_wr;
        logic [15:0] psw_wdata;
    } exp_t;

    always #5 clk_i = ~clk_i;

    mem_access_sequencer #(
        .WORD(16),
        .PSW_ADDR(PSW_ADDR),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .req_i(req_i),
        .we_i(we_i),
        .byteEn_i(byteEn_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .ack_o(ack_o),
        .rdata_o(rdata_o),
        .fault_o(fault_o),
        .faultCode_o(faultCode_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_rdy_i(mem_rdy_i),
        .psw_i(psw_i),
        .psw_we_o(psw_we_o),
        .psw_wdata_o(psw_wdata_o)
    );

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Whole-transaction prediction: latency, bus cycles held, lane data and returned status.
    function automatic exp_t predict(input bit we, input bit byte_acc, input logic [15:0] addr,
                                     input logic [15:0] wdata, input logic [15:0] psw,
                                     input logic [15:0] mrdata, input int waits);
        exp_t e;
        e = '0;
        if (!byte_acc && addr[0]) begin
            e.lat  = 1;
            e.code = 2'd1;
        end else if (addr == PSW_ADDR) begin
            e.lat = 2;
            if (we) begin
                e.psw_wr    = 1'b1;
                e.psw_wdata = byte_acc ? ((psw & 16'hFF00) | (wdata & 16'h00FF)) : wdata;
            end else begin
                e.rdata = byte_acc ? (psw & 16'h00FF) : psw;
            end
        end else begin
            e.sel       = byte_acc ? (addr[0] ? 2'd2 : 2'd1) : 2'd3;
            e.bus_wdata = byte_acc ? ((wdata & 16'h00FF) * 16'h0101) : wdata;
            if (TO_EN && waits >= TO) begin
                e.bus_cyc = TO;
                e.lat     = TO + 1;
                e.code    = 2'd2;
            end else begin
                e.bus_cyc = waits + 1;
                e.lat     = waits + 2;
                if (!we) begin
                    e.rdata = byte_acc ? (addr[0] ? (mrdata / 16'd256) : (mrdata % 16'd256)) : mrdata;
                end
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input string tag, input bit we, input bit byte_acc,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] psw, input logic [15:0] mrdata, input int waits);
        exp_t e;
        bit   acked;
        bit   exp_req;
        e = predict(we, byte_acc, addr, wdata, psw, mrdata, waits);
        acked = 1'b0;
        @(negedge clk_i);
        req_i       = 1'b1;
        we_i        = we;
        byteEn_i    = byte_acc;
        addr_i      = addr;
        wdata_i     = wdata;
        psw_i       = psw;
        mem_rdata_i = mrdata;
        mem_rdy_i   = 1'($urandom_range(0, 1));
        for (int c = 1; c <= e.lat && !acked; c++) begin
            @(negedge clk_i);
            exp_req = (c <= e.bus_cyc);
            checkOutput({tag, "/mem_req"}, mem_req_o, exp_req);
            if (exp_req) begin
                checkOutput({tag, "/mem_sel"}, mem_sel_o, e.sel);
                checkOutput({tag, "/mem_addr"}, mem_addr_o, addr);
                checkOutput({tag, "/mem_we"}, mem_we_o, we);
                if (we) checkOutput({tag, "/mem_wdata"}, mem_wdata_o, e.bus_wdata);
            end
            checkOutput({tag, "/psw_we"}, psw_we_o, e.psw_wr && c == 1);
            if (e.psw_wr && c == 1) checkOutput({tag, "/psw_wdata"}, psw_wdata_o, e.psw_wdata);
            checkOutput({tag, "/ack"}, ack_o, c == e.lat);
            if (c == e.lat) begin
                checkOutput({tag, "/rdata"}, rdata_o, e.rdata);
                checkOutput({tag, "/fault"}, fault_o, e.code != 2'd0);
                checkOutput({tag, "/fault_code"}, faultCode_o, e.code);
                acked = 1'b1;
                req_i = 1'b0;
            end else begin
                checkOutput({tag, "/fault_idle"}, fault_o, 1'b0);
            end
            if (e.bus_cyc > 0) mem_rdy_i = (c == waits + 1);
            else               mem_rdy_i = 1'($urandom_range(0, 1));
        end
        @(negedge clk_i);
        mem_rdy_i = 1'b0;
        checkOutput({tag, "/ack_single"}, ack_o, 1'b0);
        checkOutput({tag, "/mem_req_after"}, mem_req_o, 1'b0);
    endtask

    initial begin
        logic [15:0] addr;
        $display("[TB] reset checks");
        repeat (2) @(negedge clk_i);
        checkOutput("reset/ack", ack_o, 1'b0);
        checkOutput("reset/mem_req", mem_req_o, 1'b0);
        checkOutput("reset/rdata", rdata_o, 16'h0000);
        checkOutput("reset/psw_we", psw_we_o, 1'b0);
        checkOutput("reset/fault_code", faultCode_o, 2'd0);
        rst_n_i = 1'b1;

        $display("[TB] directed accesses");
        applyStimulus("word_load", 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'hBEEF, 2);
        applyStimulus("byte_load_hi", 1'b0, 1'b1, 16'h0101, 16'h0000, 16'h0000, 16'h5AA5, 0);
        applyStimulus("misaligned_store", 1'b1, 1'b0, 16'h0203, 16'h1234, 16'h0000, 16'h0000, 0);
        applyStimulus("psw_byte_store", 1'b1, 1'b1, 16'hFFFC, 16'h0012, 16'hAB00, 16'h0000, 0);
        applyStimulus("psw_word_load", 1'b0, 1'b0, 16'hFFFC, 16'h0000, 16'hC3A5, 16'h0000, 0);
        applyStimulus("psw_misaligned", 1'b0, 1'b0, 16'hFFFD, 16'h0000, 16'hC3A5, 16'h0000, 0);
        applyStimulus("byte_store_lo", 1'b1, 1'b1, 16'h0400, 16'h77C4, 16'h0000, 16'h0000, 1);

        $display("[TB] reset during bus cycle");
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; byteEn_i = 1'b0; addr_i = 16'h0300; mem_rdy_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rst_mid/mem_req_before", mem_req_o, 1'b1);
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("rst_mid/mem_req_drop", mem_req_o, 1'b0);
        checkOutput("rst_mid/mem_addr", mem_addr_o, 16'h0000);
        req_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("rst_mid/no_ack", ack_o, 1'b0);
        end
        rst_n_i = 1'b1;
        applyStimulus("after_reset", 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h0000, 16'h0F0F, 1);

        $display("[TB] long waits (timeout when enabled)");
        applyStimulus("wait_long", 1'b0, 1'b0, 16'h0500, 16'h0000, 16'h0000, 16'h1357, 9);
        applyStimulus("wait_edge", 1'b0, 1'b0, 16'h0502, 16'h0000, 16'h0000, 16'h2468, TO - 1);

        $display("[TB] randomized accesses");
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       addr = PSW_ADDR;
                1:       addr = PSW_ADDR + 16'd1;
                default: addr = 16'($urandom);
            endcase
            applyStimulus("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr,
                          16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 5)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
